// File: rtl/bgpu_tblock_dispatcher_if.sv
// Register-window and thread-block dispatch signals of the BGPU dispatcher.
// slave = dispatcher side, master = system bus / compute cluster side.
interface bgpu_tblock_dispatcher_if #(
  parameter int unsigned PcWidth        = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned TblockIdxWidth = 28,
  parameter int unsigned TgroupIdWidth  = 8,
  parameter int unsigned NumCus         = 2
);
  logic                      reg_req;
  logic                      reg_we;
  logic [4:0]                reg_addr;
  logic [31:0]               reg_wdata;
  logic                      reg_rvalid;
  logic [31:0]               reg_rdata;
  logic                      reg_error;
  logic                      tblock_valid;
  logic                      tblock_ready;
  logic [PcWidth-1:0]        tblock_pc;
  logic [AddressWidth-1:0]   tblock_dp_addr;
  logic [TblockIdxWidth-1:0] tblock_idx;
  logic [TgroupIdWidth-1:0]  tblock_tgroup_id;
  logic [NumCus-1:0]         tblock_done;

  modport slave (
    input  reg_req, reg_we, reg_addr, reg_wdata, tblock_ready, tblock_done,
    output reg_rvalid, reg_rdata, reg_error,
    output tblock_valid, tblock_pc, tblock_dp_addr, tblock_idx, tblock_tgroup_id
  );

  modport master (
    output reg_req, reg_we, reg_addr, reg_wdata, tblock_ready, tblock_done,
    input  reg_rvalid, reg_rdata, reg_error,
    input  tblock_valid, tblock_pc, tblock_dp_addr, tblock_idx, tblock_tgroup_id
  );
endinterface

// File: rtl/bgpu_tblock_dispatcher.sv
// BGPU thread-block dispatcher: holds the kernel launch configuration,
// issues thread blocks one at a time and counts their completions.
module bgpu_tblock_dispatcher #(
  parameter int unsigned PcWidth        = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned TblockIdxWidth = 28,
  parameter int unsigned TgroupIdWidth  = 8,
  parameter int unsigned NumCus         = 2
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  bgpu_tblock_dispatcher_if.slave bus
);
  localparam int unsigned PopW = $clog2(NumCus + 1);
  localparam int unsigned CntW = TblockIdxWidth + 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_DONE, FINISHED} state_e;

  state_e                    state;
  logic [PcWidth-1:0]        pc;
  logic [AddressWidth-1:0]   dp_addr;
  logic [TblockIdxWidth-1:0] num_tblocks;
  logic [TgroupIdWidth-1:0]  tgroup_id;
  logic                      start_pending;
  logic                      finished;
  logic [TblockIdxWidth-1:0] finished_cnt;
  logic [TblockIdxWidth-1:0] idx;
  logic                      rvalid;
  logic [31:0]               rdata;
  logic                      error;

  logic                      running;
  logic                      addr_ok;
  logic                      is_status;
  logic                      cfg_we;
  logic                      start_we;
  logic [31:0]               rd_word;
  logic [PopW-1:0]           done_pop;
  logic [CntW-1:0]           cnt_sum;
  logic [TblockIdxWidth-1:0] cnt_next;

  assign running   = (state == DISPATCH) || (state == WAIT_DONE);
  assign addr_ok   = (bus.reg_addr[1:0] == 2'b00) && (bus.reg_addr <= 5'h10);
  assign is_status = (bus.reg_addr == 5'h10);
  assign cfg_we    = bus.reg_req && bus.reg_we && addr_ok && !is_status && !running;
  assign start_we  = bus.reg_req && bus.reg_we && is_status && !running;

  // Read mux over the current register contents, narrow fields zero-extended.
  always_comb begin
    rd_word = '0;
    case (bus.reg_addr)
      5'h00:   rd_word = 32'(pc);
      5'h04:   rd_word = 32'(dp_addr);
      5'h08:   rd_word = 32'(num_tblocks);
      5'h0C:   rd_word = 32'(tgroup_id);
      5'h10:   rd_word = 32'({finished_cnt, 1'b0, finished, running, start_pending});
      default: rd_word = '0;
    endcase
  end

  // Completion count update: popcount of this cycle's pulses, saturating at the block count.
  always_comb begin
    done_pop = '0;
    for (int i = 0; i < NumCus; i++) begin
      done_pop = done_pop + PopW'(bus.tblock_done[i]);
    end
    cnt_sum  = {1'b0, finished_cnt} + CntW'(done_pop);
    cnt_next = (cnt_sum > {1'b0, num_tblocks}) ? num_tblocks : cnt_sum[TblockIdxWidth-1:0];
  end

  // Register window, launch FSM and completion counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      pc            <= '0;
      dp_addr       <= '0;
      num_tblocks   <= '0;
      tgroup_id     <= '0;
      start_pending <= 1'b0;
      finished      <= 1'b0;
      finished_cnt  <= '0;
      idx           <= '0;
      rvalid        <= 1'b0;
      rdata         <= '0;
      error         <= 1'b0;
    end else begin
      rvalid <= bus.reg_req;
      error  <= bus.reg_req && (!addr_ok || (bus.reg_we && running));
      rdata  <= (bus.reg_req && !bus.reg_we && addr_ok) ? rd_word : '0;

      if (cfg_we) begin
        case (bus.reg_addr)
          5'h00:   pc          <= bus.reg_wdata[PcWidth-1:0];
          5'h04:   dp_addr     <= bus.reg_wdata[AddressWidth-1:0];
          5'h08:   num_tblocks <= bus.reg_wdata[TblockIdxWidth-1:0];
          default: tgroup_id   <= bus.reg_wdata[TgroupIdWidth-1:0];
        endcase
      end
      if (start_we) begin
        start_pending <= 1'b1;
      end

      case (state)
        IDLE, FINISHED: begin
          // Launch: a start write landing in this same cycle is absorbed.
          if (start_pending) begin
            state         <= DISPATCH;
            start_pending <= 1'b0;
            finished_cnt  <= '0;
            idx           <= '0;
            finished      <= 1'b0;
          end
        end
        DISPATCH: begin
          finished_cnt <= cnt_next;
          if (num_tblocks == '0) begin
            state    <= FINISHED;
            finished <= 1'b1;
          end else if (bus.tblock_ready) begin
            idx <= idx + TblockIdxWidth'(1);
            if (idx == num_tblocks - TblockIdxWidth'(1)) begin
              state <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          finished_cnt <= cnt_next;
          if (cnt_next == num_tblocks) begin
            state    <= FINISHED;
            finished <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.reg_rvalid       = rvalid;
  assign bus.reg_rdata        = rdata;
  assign bus.reg_error        = error;
  assign bus.tblock_valid     = (state == DISPATCH) && (num_tblocks != '0);
  assign bus.tblock_pc        = pc;
  assign bus.tblock_dp_addr   = dp_addr;
  assign bus.tblock_idx       = idx;
  assign bus.tblock_tgroup_id = tgroup_id;
endmodule

// File: tb/tb_bgpu_tblock_dispatcher.sv
// Scoreboard bench for bgpu_tblock_dispatcher: stimulus pushes expected
// register responses and dispatches; monitors pop and compare.
`timescale 1ns/1ps
module tb_bgpu_tblock_dispatcher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bgpu_tblock_dispatcher_if #(.PcWidth(32), .AddressWidth(32), .TblockIdxWidth(28),
                              .TgroupIdWidth(8), .NumCus(2)) bus ();

  bgpu_tblock_dispatcher #(.PcWidth(32), .AddressWidth(32), .TblockIdxWidth(28),
                           .TgroupIdWidth(8), .NumCus(2)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
    logic [4:0]  addr;
  } reg_exp_t;

  typedef struct {
    logic [27:0] idx;
    logic [31:0] pc;
    logic [31:0] dp;
    logic [7:0]  tg;
  } hs_exp_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  reg_exp_t    reg_q[$];
  hs_exp_t     hs_q[$];
  int unsigned sched[$];
  logic [31:0] m_regs[4];
  bit          m_running = 0;
  int          hs_count = 0;
  int          dones_sent = 0;
  int          valid_cycles = 0;
  int          ready_mode = 0;     // 0 high, 1 random, 2 low
  bit          rand_delay = 0;
  bit          check_consec = 0;
  bit          manual_done = 0;
  logic [1:0]  manual_val = 2'b00;
  int unsigned last_hs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_op(input bit we, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input bit exp_err);
    reg_exp_t e;
    bus.reg_req   = 1'b1;
    bus.reg_we    = we;
    bus.reg_addr  = addr;
    bus.reg_wdata = wdata;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.cyc   = cyc;
    e.addr  = addr;
    reg_q.push_back(e);
    @(posedge clk);
    #1;
    bus.reg_req   = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
  endtask

  function automatic logic [31:0] field_mask(input int i);
    if (i == 2) return 32'h0FFF_FFFF;
    if (i == 3) return 32'h0000_00FF;
    return 32'hFFFF_FFFF;
  endfunction

  task automatic cfg_write(input int i, input logic [31:0] val);
    reg_op(1'b1, 5'(i * 4), val, 32'h0, m_running);
    if (!m_running) m_regs[i] = val & field_mask(i);
  endtask

  task automatic cfg_read(input int i);
    reg_op(1'b0, 5'(i * 4), 32'h0, m_regs[i], 1'b0);
  endtask

  task automatic status_read(input logic [31:0] exp);
    reg_op(1'b0, 5'h10, 32'h0, exp, 1'b0);
  endtask

  // Start a run: when accepted, every block 0..NUM-1 is expected once, in order.
  task automatic start_run();
    hs_exp_t h;
    bit accepted;
    accepted = !m_running;
    reg_op(1'b1, 5'h10, $urandom, 32'h0, m_running);
    if (accepted) begin
      hs_count   = 0;
      dones_sent = 0;
      m_running  = 1;
      for (int i = 0; i < int'(m_regs[2]); i++) begin
        h.idx = 28'(i);
        h.pc  = m_regs[0];
        h.dp  = m_regs[1];
        h.tg  = m_regs[3][7:0];
        hs_q.push_back(h);
      end
    end
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 3000 && hs_count < n; i++) idle(1);
    chk("handshake count", 32'(hs_count), 32'(n));
  endtask

  task automatic wait_dones(input int n);
    for (int i = 0; i < 3000 && dones_sent < n; i++) idle(1);
    chk("done pulses returned", 32'(dones_sent), 32'(n));
    idle(3);
    m_running = 0;
  endtask

  // Ready driver.
  initial begin
    bus.tblock_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.tblock_ready = 1'b1;
        1:       bus.tblock_ready = 1'($urandom_range(0, 1));
        default: bus.tblock_ready = 1'b0;
      endcase
    end
  end

  // Completion driver: up to two scheduled completions per cycle, surplus deferred.
  initial begin
    logic [1:0] d;
    int k;
    int i;
    bus.tblock_done = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      d = 2'b00;
      k = 0;
      i = 0;
      while (i < sched.size()) begin
        if (sched[i] <= cyc && k < 2) begin
          d[k] = 1'b1;
          k++;
          sched.delete(i);
          dones_sent++;
        end else begin
          i++;
        end
      end
      bus.tblock_done = manual_done ? manual_val : d;
    end
  end

  // Monitor: register responses and dispatch handshakes.
  initial begin
    reg_exp_t e;
    hs_exp_t  h;
    hs_exp_t  held;
    bit       stall_prev;
    stall_prev = 0;
    held = '{default: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0;
      end else begin
        if (bus.reg_rvalid) begin
          if (reg_q.size() == 0) begin
            chk("unexpected rvalid", 32'(bus.reg_rvalid), 32'h0);
          end else begin
            e = reg_q.pop_front();
            $display("reg rsp addr=0x%02h rdata=0x%08h err=%0d", e.addr, bus.reg_rdata, bus.reg_error);
            chk("rvalid latency", cyc, e.cyc + 1);
            chk("rdata", bus.reg_rdata, e.rdata);
            chk("error", 32'(bus.reg_error), 32'(e.err));
          end
        end else begin
          chk("rdata idle", bus.reg_rdata, 32'h0);
        end

        if (bus.tblock_valid) begin
          valid_cycles++;
          if (stall_prev) begin
            chk("stall idx", 32'(bus.tblock_idx), 32'(held.idx));
            chk("stall pc", bus.tblock_pc, held.pc);
            chk("stall dp", bus.tblock_dp_addr, held.dp);
            chk("stall tg", 32'(bus.tblock_tgroup_id), 32'(held.tg));
          end
          if (bus.tblock_ready) begin
            hs_count++;
            $display("dispatch idx=%0d pc=0x%08h dp=0x%08h tg=0x%02h",
                     bus.tblock_idx, bus.tblock_pc, bus.tblock_dp_addr, bus.tblock_tgroup_id);
            if (hs_q.size() == 0) begin
              chk("unexpected dispatch", 32'(bus.tblock_valid), 32'h0);
            end else begin
              h = hs_q.pop_front();
              chk("dispatch idx", 32'(bus.tblock_idx), 32'(h.idx));
              chk("dispatch pc", bus.tblock_pc, h.pc);
              chk("dispatch dp", bus.tblock_dp_addr, h.dp);
              chk("dispatch tg", 32'(bus.tblock_tgroup_id), 32'(h.tg));
            end
            if (check_consec && hs_count > 1) chk("back-to-back dispatch", cyc, last_hs_cyc + 1);
            last_hs_cyc = cyc;
            if (!manual_done) sched.push_back(cyc + (rand_delay ? $urandom_range(1, 8) : 5));
          end
        end else if (stall_prev) begin
          chk("valid dropped while stalled", 32'(bus.tblock_valid), 32'h1);
        end
        stall_prev = bus.tblock_valid && !bus.tblock_ready;
        held.idx = bus.tblock_idx;
        held.pc  = bus.tblock_pc;
        held.dp  = bus.tblock_dp_addr;
        held.tg  = bus.tblock_tgroup_id;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 2ms", $time);
    $fatal(1);
  end

  initial begin
    int v0;
    bus.reg_req = 1'b0;
    bus.reg_we = 1'b0;
    bus.reg_addr = '0;
    bus.reg_wdata = '0;
    for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset valid", 32'(bus.tblock_valid), 32'h0);
    chk("reset rvalid", 32'(bus.reg_rvalid), 32'h0);
    idle(1);
    for (int i = 0; i < 4; i++) cfg_read(i);
    status_read(32'h0);

    // Configuration and unmapped accesses.
    cfg_write(0, 32'h0);
    cfg_write(1, 32'h1);
    cfg_write(2, 32'd24);
    cfg_write(3, 32'h2);
    for (int i = 0; i < 4; i++) cfg_read(i);
    reg_op(1'b0, 5'h14, 32'h0, 32'h0, 1'b1);
    reg_op(1'b0, 5'h02, 32'h0, 32'h0, 1'b1);
    reg_op(1'b1, 5'h18, 32'hFFFF_FFFF, 32'h0, 1'b1);
    cfg_read(0);

    // Run 1: ready high, completions 5 cycles after each dispatch.
    check_consec = 1;
    start_run();
    status_read(32'h1);
    status_read(32'h2);
    wait_hs(24);
    wait_dones(24);
    check_consec = 0;
    status_read((32'd24 << 4) | 32'h4);

    // Run 2: new payload, random ready and completion delay; restart clears the count.
    cfg_write(0, $urandom);
    cfg_write(1, $urandom);
    cfg_write(3, $urandom);
    ready_mode = 1;
    rand_delay = 1;
    start_run();
    status_read((32'd24 << 4) | 32'h5);
    status_read(32'h2);
    cfg_write(0, 32'hDEAD_BEEF);
    cfg_read(0);
    start_run();
    wait_hs(24);
    wait_dones(24);
    status_read((32'd24 << 4) | 32'h4);

    // Simultaneous completions, saturation, and pulses ignored once finished.
    ready_mode = 0;
    manual_done = 1;
    cfg_write(2, 32'd3);
    start_run();
    wait_hs(3);
    idle(2);
    status_read(32'h02);
    manual_val = 2'b11;
    idle(1);
    manual_val = 2'b00;
    idle(1);
    status_read(32'h22);
    manual_val = 2'b11;
    idle(1);
    manual_val = 2'b00;
    idle(1);
    status_read(32'h34);
    manual_val = 2'b11;
    idle(1);
    manual_val = 2'b00;
    idle(1);
    status_read(32'h34);
    m_running = 0;
    manual_done = 0;

    // Zero blocks: finishes without any dispatch.
    cfg_write(2, 32'd0);
    v0 = valid_cycles;
    start_run();
    idle(4);
    status_read(32'h4);
    chk("valid cycles for zero blocks", 32'(valid_cycles - v0), 32'h0);
    m_running = 0;

    // Reset in the middle of a stalled dispatch.
    cfg_write(2, 32'd24);
    ready_mode = 2;
    start_run();
    idle(4);
    chk("valid before reset", 32'(bus.tblock_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("valid during reset", 32'(bus.tblock_valid), 32'h0);
    idle(2);
    hs_q.delete();
    sched.delete();
    for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
    m_running = 0;
    rst_n = 1'b1;
    ready_mode = 0;
    idle(1);
    status_read(32'h0);
    cfg_read(2);
    idle(3);

    chk("pending register responses", 32'(reg_q.size()), 32'h0);
    chk("pending dispatches", 32'(hs_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
